// File: rtl/multi_nbit_serial.sv
// Bit-serial WIDTH x WIDTH multiplier with LSB-first operands and product, unsigned or two's complement.
// Define MULT_SERIAL_OVERLAP_EN to double-buffer operands so consecutive products stream back-to-back.
module multi_nbit_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic TC,
  input  logic IN_VALID,
  output logic IN_READY,
  input  logic A,
  input  logic B,
  output logic O,
  output logic O_VALID,
  output logic O_LAST
);

  localparam int unsigned ICW = $clog2(WIDTH);
  localparam int unsigned RCW = $clog2(2 * WIDTH);
  localparam logic [ICW-1:0] IN_LAST  = ICW'(WIDTH - 1);
  localparam logic [RCW-1:0] OUT_LAST = RCW'(2 * WIDTH - 1);
  localparam logic [RCW-1:0] SUB_IDX  = RCW'(WIDTH - 1);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Load buffer: collects the incoming frame.
  logic [ICW-1:0]   in_cnt_q, in_cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             tc_q, tc_d;
  logic             full_q, full_d;

  // Active frame: operands of the product currently being emitted.
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] act_a_q, act_a_d;
  logic [WIDTH-1:0] act_b_q, act_b_d;
  logic             act_tc_q, act_tc_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [RCW-1:0]   run_cnt_q, run_cnt_d;

  logic             o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic             o_last_q, o_last_d;

  logic             in_ready;
  logic             accept;
  logic             last_accept;
  logic             frame_rdy;
  logic             at_last;
  logic             start;
  logic [WIDTH-1:0] fa, fb;

  logic [WIDTH-1:0] s_a, s_b, a_sh;
  logic             s_tc;
  logic [WIDTH:0]   s_acc, pp, sum;
  logic [RCW-1:0]   s_idx;
  logic             step_bit;
  logic [WIDTH:0]   step_acc;

  always_comb begin
    at_last = (state_q == ST_RUN) && (run_cnt_q == OUT_LAST);
`ifdef MULT_SERIAL_OVERLAP_EN
    // The buffer frees on the O_LAST edge, so a new bit 0 may land that same edge.
    in_ready = !full_q || at_last;
`else
    in_ready = (state_q == ST_LOAD);
`endif
    accept      = IN_VALID && in_ready;
    last_accept = accept && (in_cnt_q == IN_LAST);
    frame_rdy   = full_q || last_accept;
    start       = frame_rdy && ((state_q == ST_LOAD) || at_last);

    // A frame finishing this edge still has its top bits on the pins.
    fa = a_q;
    fb = b_q;
    if (last_accept) begin
      fa[WIDTH-1] = A;
      fb[WIDTH-1] = B;
    end
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    tc_d     = tc_q;
    in_cnt_d = in_cnt_q;
    if (accept) begin
      a_d[in_cnt_q] = A;
      b_d[in_cnt_q] = B;
      if (in_cnt_q == '0) begin
        tc_d = TC;
      end
      in_cnt_d = last_accept ? '0 : in_cnt_q + 1'b1;
    end
    full_d = frame_rdy && !start;
  end

  // One shift-add step. Sign of A is handled by subtracting its top partial product,
  // so the accumulator always holds the true partial sum and later steps add nothing.
  always_comb begin
    if (start) begin
      s_a   = fa;
      s_b   = fb;
      s_tc  = tc_q;
      s_acc = '0;
      s_idx = '0;
    end else begin
      s_a   = act_a_q;
      s_b   = act_b_q;
      s_tc  = act_tc_q;
      s_acc = acc_q;
      s_idx = run_cnt_q + 1'b1;
    end
    a_sh     = s_a >> s_idx;
    pp       = a_sh[0] ? {s_tc & s_b[WIDTH-1], s_b} : '0;
    sum      = (s_tc && (s_idx == SUB_IDX)) ? s_acc - pp : s_acc + pp;
    step_bit = sum[0];
    step_acc = {s_tc & sum[WIDTH], sum[WIDTH:1]};
  end

  always_comb begin
    state_d   = state_q;
    act_a_d   = act_a_q;
    act_b_d   = act_b_q;
    act_tc_d  = act_tc_q;
    acc_d     = acc_q;
    run_cnt_d = run_cnt_q;
    o_d       = 1'b0;
    o_valid_d = 1'b0;
    o_last_d  = 1'b0;
    if (start) begin
      state_d   = ST_RUN;
      act_a_d   = fa;
      act_b_d   = fb;
      act_tc_d  = tc_q;
      acc_d     = step_acc;
      run_cnt_d = '0;
      o_d       = step_bit;
      o_valid_d = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (at_last) begin
        state_d = ST_LOAD;
      end else begin
        acc_d     = step_acc;
        run_cnt_d = s_idx;
        o_d       = step_bit;
        o_valid_d = 1'b1;
        o_last_d  = (s_idx == OUT_LAST);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_cnt_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tc_q      <= 1'b0;
      full_q    <= 1'b0;
      state_q   <= ST_LOAD;
      act_a_q   <= '0;
      act_b_q   <= '0;
      act_tc_q  <= 1'b0;
      acc_q     <= '0;
      run_cnt_q <= '0;
      o_q       <= 1'b0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tc_q      <= tc_d;
      full_q    <= full_d;
      state_q   <= state_d;
      act_a_q   <= act_a_d;
      act_b_q   <= act_b_d;
      act_tc_q  <= act_tc_d;
      acc_q     <= acc_d;
      run_cnt_q <= run_cnt_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
    end
  end

  assign IN_READY = in_ready;
  assign O        = o_q;
  assign O_VALID  = o_valid_q;
  assign O_LAST   = o_last_q;

endmodule
